// File: rtl/keypad_pkg.sv
//==============================================================================
// Module   : keypad_pkg
// Brief    : Shared FSM state type, fixed keymap and key-code constants for
//            the 4x4 keypad scanner.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } keypad_state_e;

    localparam logic [3:0] c_key_star = 4'hE;
    localparam logic [3:0] c_key_hash = 4'hF;

    // Indexed by {row, col}; row 0 is the top row of the pad.
    localparam logic [3:0] c_keymap [16] = '{
        4'h1,       4'h2, 4'h3,       4'hA,
        4'h4,       4'h5, 4'h6,       4'hB,
        4'h7,       4'h8, 4'h9,       4'hC,
        c_key_star, 4'h0, c_key_hash, 4'hD
    };

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_if.sv
//==============================================================================
// Module   : keypad_scanner_if
// Brief    : Keypad matrix pins and decoded key outputs of the scanner.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

`default_nettype wire

// File: rtl/keypad_debounce.sv
//==============================================================================
// Module   : keypad_debounce
// Brief    : Counts consecutive row samples matching a masked reference;
//            shared by press and release qualification.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module keypad_debounce #(
    parameter int DEBOUNCE_CNT = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_clear,
    input  wire logic       i_start,
    input  wire logic       i_sample_en,
    input  wire logic [3:0] i_sample,
    input  wire logic [3:0] i_ref_pattern,
    input  wire logic [3:0] i_mask,
    output logic            o_done,
    output logic            o_mismatch
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE_CNT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CNT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_match;

    assign w_match    = ((i_sample ^ i_ref_pattern) & i_mask) == 4'h0;
    assign o_done     = i_sample_en && w_match && (r_cnt >= c_cnt_last);
    assign o_mismatch = i_sample_en && !w_match;

    // The sample that triggers a start is itself the first matching one.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= c_cnt_w'(1);
        end else if (i_sample_en) begin
            if (!w_match)                r_cnt <= '0;
            else if (r_cnt >= c_cnt_max) r_cnt <= c_cnt_max;
            else                         r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
//==============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with two-flop row sync, debounced
//            press/release and single-key lockout. Define KEYPAD_REPEAT_EN
//            for auto-repeat strobes while a key is held.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 16,
    parameter int REPEAT_DELAY  = 400,
    parameter int REPEAT_PERIOD = 100
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    keypad_scanner_if.master kp
);

    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);

    if (SCAN_DIV < 1 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("keypad_scanner: all timing parameters must be at least 1");
    end

    keypad_state_e      r_state, w_state_next;
    logic [3:0]         r_row_s1, r_row_s2;
    logic [c_div_w-1:0] r_div_cnt;
    logic [1:0]         r_col, r_row_lat;
    logic [3:0]         r_pat, r_key_code;
    logic               r_key_valid;

    logic [3:0] w_sample, w_db_ref, w_db_mask;
    logic       w_tick, w_latch, w_advance, w_accept, w_repeat;
    logic       w_db_clear, w_db_start, w_db_en, w_db_done, w_db_mismatch;

    assign w_sample = r_row_s2;
    assign w_tick   = (r_div_cnt == c_div_last);

    assign w_db_en   = w_tick && (r_state == ST_DEBOUNCE || r_state == ST_RELEASE);
    assign w_db_ref  = (r_state == ST_RELEASE) ? 4'hF : r_pat;
    assign w_db_mask = (r_state == ST_RELEASE) ? (4'b0001 << r_row_lat) : 4'hF;

    keypad_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_db_clear),
        .i_start       (w_db_start),
        .i_sample_en   (w_db_en),
        .i_sample      (w_sample),
        .i_ref_pattern (w_db_ref),
        .i_mask        (w_db_mask),
        .o_done        (w_db_done),
        .o_mismatch    (w_db_mismatch)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_SCAN;
        else        r_state <= w_state_next;
    end

    // Column stays frozen outside SCAN; it only steps on an idle sample or
    // after a completed release. An aborted press re-scans the same column.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_advance    = 1'b0;
        w_accept     = 1'b0;
        w_db_clear   = 1'b0;
        w_db_start   = 1'b0;
        unique case (r_state)
            ST_SCAN: begin
                w_db_clear = 1'b1;
                if (w_tick) begin
                    if (w_sample != 4'hF) begin
                        w_state_next = ST_DEBOUNCE;
                        w_latch      = 1'b1;
                        w_db_clear   = 1'b0;
                        w_db_start   = 1'b1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (w_db_mismatch) begin
                    w_state_next = ST_SCAN;
                end else if (w_db_done) begin
                    w_state_next = ST_HELD;
                    w_accept     = 1'b1;
                end
            end
            ST_HELD: begin
                w_db_clear = 1'b1;
                if (w_tick && w_sample[r_row_lat]) begin
                    w_state_next = ST_RELEASE;
                    w_db_clear   = 1'b0;
                    w_db_start   = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (w_db_mismatch) begin
                    w_state_next = ST_HELD;
                end else if (w_db_done) begin
                    w_state_next = ST_SCAN;
                    w_advance    = 1'b1;
                end
            end
            default: w_state_next = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_s1    <= 4'hF;
            r_row_s2    <= 4'hF;
            r_div_cnt   <= '0;
            r_col       <= 2'd0;
            r_row_lat   <= 2'd0;
            r_pat       <= 4'hF;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_row_s1    <= kp.row_in;
            r_row_s2    <= r_row_s1;
            r_div_cnt   <= w_tick ? '0 : r_div_cnt + c_div_w'(1);
            r_key_valid <= w_accept | w_repeat;
            if (w_latch) begin
                r_pat     <= w_sample;
                r_row_lat <= lowest_low_row(w_sample);
            end
            if (w_advance) r_col <= r_col + 2'd1;
            if (w_accept)  r_key_code <= c_keymap[{r_row_lat, r_col}];
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rep_w   = $clog2(c_rep_max + 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_rep_armed;
    logic               w_rep_hit, w_rep_step;

    assign w_rep_step = (r_state == ST_HELD) && w_tick && !w_sample[r_row_lat];
    assign w_rep_hit  = r_rep_armed ? (r_rep_cnt == c_rep_w'(REPEAT_PERIOD - 1))
                                    : (r_rep_cnt == c_rep_w'(REPEAT_DELAY - 1));
    assign w_repeat   = w_rep_step && w_rep_hit;

    // Cleared whenever not in HELD, so a bounce through RELEASE restarts the delay.
    always_ff @(posedge clk) begin
        if (!rst_n || r_state != ST_HELD) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_step) begin
            if (w_rep_hit) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign kp.col_out   = ~(4'b0001 << r_col);
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = (r_state == ST_HELD) || (r_state == ST_RELEASE);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
//==============================================================================
// Module   : tb_keypad_scanner
// Brief    : Directed vector bench for keypad_scanner with a keypad model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_CNT  (8),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp_if.master)
    );

    // Keypad model: the pressed key pulls its row low only while its column is driven.
    logic       key_down;
    logic [1:0] key_row, key_col;
    always_comb begin
        kp_if.row_in = 4'hF;
        if (key_down && (kp_if.col_out[key_col] == 1'b0)) kp_if.row_in[key_row] = 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int samp_idx = 0;
    int strobe_cnt = 0;
    int log_n = 0;
    int log_idx [8];
    logic [3:0] log_code [8];

    always @(negedge clk) begin
        if (kp_if.key_valid === 1'b1) begin
            strobe_cnt++;
            if (log_n < 8) begin
                log_idx[log_n]  = samp_idx;
                log_code[log_n] = kp_if.key_code;
                log_n++;
            end
        end
    end

    typedef struct {
        bit         down;
        logic [3:0] key;
        int         n;
        int         exp_strobes;
        logic [3:0] exp_code;
        bit         exp_held;
        logic [3:0] exp_col;
    } vec_t;

    function automatic vec_t mk(bit d, logic [3:0] k, int n, int s, logic [3:0] c, bit h, logic [3:0] col);
        vec_t v;
        v.down = d; v.key = k; v.n = n; v.exp_strobes = s;
        v.exp_code = c; v.exp_held = h; v.exp_col = col;
        return v;
    endfunction

    function automatic logic [3:0] key_pos(input logic [3:0] k);
        case (k)
            4'h1: return {2'd0, 2'd0};
            4'h2: return {2'd0, 2'd1};
            4'h3: return {2'd0, 2'd2};
            4'hA: return {2'd0, 2'd3};
            4'h4: return {2'd1, 2'd0};
            4'h5: return {2'd1, 2'd1};
            4'h6: return {2'd1, 2'd2};
            4'hB: return {2'd1, 2'd3};
            4'h7: return {2'd2, 2'd0};
            4'h8: return {2'd2, 2'd1};
            4'h9: return {2'd2, 2'd2};
            4'hC: return {2'd2, 2'd3};
            4'hE: return {2'd3, 2'd0};
            4'h0: return {2'd3, 2'd1};
            4'hF: return {2'd3, 2'd2};
            default: return {2'd3, 2'd3};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic press(input bit dn, input logic [3:0] k);
        {key_row, key_col} = key_pos(k);
        key_down = dn;
    endtask

    // One dwell of 4 clocks; returns mid-cycle after the sampling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (4) @(posedge clk);
            samp_idx++;
            @(negedge clk);
            #1;
        end
    endtask

    vec_t vecs [15];
    int   base;
    int   exp_n;
    int   exp_idx [8];

    initial begin
        vecs[0]  = mk(0, 4'h0,  1, 0, 4'h0, 0, 4'b1101);
        vecs[1]  = mk(0, 4'h0,  2, 0, 4'h0, 0, 4'b0111);
        vecs[2]  = mk(0, 4'h0,  1, 0, 4'h0, 0, 4'b1110);
        vecs[3]  = mk(1, 4'h5, 12, 1, 4'h5, 1, 4'b1101);
        vecs[4]  = mk(0, 4'h0,  7, 0, 4'h5, 1, 4'b1101);
        vecs[5]  = mk(0, 4'h0,  1, 0, 4'h5, 0, 4'b1011);
        vecs[6]  = mk(1, 4'h9,  3, 0, 4'h5, 0, 4'b1011);
        vecs[7]  = mk(0, 4'h0,  1, 0, 4'h5, 0, 4'b1011);
        vecs[8]  = mk(1, 4'h9,  7, 0, 4'h5, 0, 4'b1011);
        vecs[9]  = mk(1, 4'h9,  3, 1, 4'h9, 1, 4'b1011);
        vecs[10] = mk(0, 4'h0,  8, 0, 4'h9, 0, 4'b0111);
        vecs[11] = mk(1, 4'hF, 12, 1, 4'hF, 1, 4'b1011);
        vecs[12] = mk(0, 4'h0,  4, 0, 4'hF, 1, 4'b1011);
        vecs[13] = mk(1, 4'hF,  3, 0, 4'hF, 1, 4'b1011);
        vecs[14] = mk(0, 4'h0,  8, 0, 4'hF, 0, 4'b0111);

        key_down = 1'b0; key_row = 2'd0; key_col = 2'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col",   32'(kp_if.col_out),   32'h e);
        chk("rst_code",  32'(kp_if.key_code),  32'h0);
        chk("rst_valid", 32'(kp_if.key_valid), 32'h0);
        chk("rst_held",  32'(kp_if.key_held),  32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            base = strobe_cnt;
            press(vecs[i].down, vecs[i].key);
            step(vecs[i].n);
            chk($sformatf("v%0d_strobes", i), 32'(strobe_cnt - base), 32'(vecs[i].exp_strobes));
            chk($sformatf("v%0d_code", i),    32'(kp_if.key_code),    32'(vecs[i].exp_code));
            chk($sformatf("v%0d_held", i),    32'(kp_if.key_held),    32'(vecs[i].exp_held));
            chk($sformatf("v%0d_col", i),     32'(kp_if.col_out),     32'(vecs[i].exp_col));
        end

        // Reset pulse in the middle of debouncing "A".
        base = strobe_cnt;
        press(1, 4'hA);
        step(3);
        chk("a_frozen_col", 32'(kp_if.col_out), 32'b0111);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("a_rst_col",   32'(kp_if.col_out),   32'he);
        chk("a_rst_code",  32'(kp_if.key_code),  32'h0);
        chk("a_rst_valid", 32'(kp_if.key_valid), 32'h0);
        chk("a_rst_held",  32'(kp_if.key_held),  32'h0);
        press(0, 4'h0);
        rst_n = 1'b1;
        samp_idx = 0;
        step(1);
        chk("a_first_col", 32'(kp_if.col_out), 32'b1101);
        step(3);
        chk("a_wrap_col",  32'(kp_if.col_out), 32'b1110);
        chk("a_strobes",   32'(strobe_cnt - base), 32'h0);

        // "0" held: accept lands on sample 13, then 40 more samples.
        log_n = 0;
        press(1, 4'h0);
        step(49);
`ifdef KEYPAD_REPEAT_EN
        exp_n = 6;
        exp_idx = '{13, 33, 38, 43, 48, 53, 0, 0};
`else
        exp_n = 1;
        exp_idx = '{13, 0, 0, 0, 0, 0, 0, 0};
`endif
        chk("rep_count", 32'(log_n), 32'(exp_n));
        for (int i = 0; i < exp_n && i < log_n; i++) begin
            chk($sformatf("rep%0d_sample", i), 32'(log_idx[i]),  32'(exp_idx[i]));
            chk($sformatf("rep%0d_code", i),   32'(log_code[i]), 32'h0);
        end
        chk("rep_held", 32'(kp_if.key_held), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
